fire_order_dispatcher: RTL

Consumes the per-instrument `fire` vector produced by the trigger stage and turns each new fire into one outbound order message. Each message is built from a per-instrument order template. Messages go out as a 3-beat, 64-bit valid/ready stream toward the order-entry encoder. Simultaneous fires are arbitrated round-robin, and each message carries a global sequence number.

---
 rtl/gg_order_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 65 ++++++
 rtl/fire_order_dispatcher.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gg_order_pkg.sv
// ---------------------------------------------------------------------------
// gg_order_pkg
// Shared types and constants for the fire order dispatcher:
//   - dispatch_state_t : dispatcher FSM states (IDLE plus one state per beat)
//   - SIDE_BUY/SIDE_SELL : side encodings (0 and 3 are reserved, passed through)
//   - BEAT_COUNT and the bit offsets of the fields inside each 64-bit beat
//   - order_tmpl_t : one slot's order template, kept packed for later port
//     bundling
// ---------------------------------------------------------------------------
package gg_order_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    BEAT2 = 2'd3
  } dispatch_state_t;

  localparam logic [1:0] SIDE_BUY  = 2'd1;
  localparam logic [1:0] SIDE_SELL = 2'd2;

  localparam int BEAT_COUNT = 3;

  // Beat 0: {security_id, size}
  localparam int B0_SIZE_LSB = 0;
  localparam int B0_ID_LSB   = 32;
  // Beat 2: {seq[15:0], 6'b0, side[1:0], slot[7:0], 32'b0}
  localparam int B2_SLOT_LSB  = 32;
  localparam int B2_SIDE_LSB  = 40;
  localparam int B2_SEQ_LSB   = 48;
  localparam int SEQ_FIELD_W  = 16;
  localparam int SLOT_FIELD_W = 8;

  typedef struct packed {
    logic [31:0] security_id;
    logic [63:0] price;
    logic [31:0] size;
    logic [1:0]  side;
  } order_tmpl_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: a pointer register plus a combinational search for the
// lowest-index request at or above the pointer, wrapping around.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (pointer -> 0)
//   req[N]            request vector
//   advance           a grant is being taken this cycle; pointer moves to
//                     grant_idx+1 (mod N)
//   grant_onehot[N]   one-hot grant (all zero when no request)
//   grant_idx         index of the granted request
//   ptr               current round-robin pointer
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;
  logic [IW-1:0] cand;

  // Walk the slots starting at the pointer; the modulo is done by a
  // conditional subtract so non-power-of-two N works too.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      if (int'(ptr_q) + off >= N) cand = IW'(int'(ptr_q) + off - N);
      else                        cand = IW'(int'(ptr_q) + off);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_onehot = '0;
    if (found) grant_onehot[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fire_order_dispatcher.sv
// ---------------------------------------------------------------------------
// fire_order_dispatcher
// Turns each rising edge of a per-instrument fire flag into one 3-beat order
// message on a 64-bit valid/ready stream. Simultaneous fires are served
// round-robin; each message carries a global sequence number.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   fire[N]               level fire flags; only rising edges count
//   security_id_orders    32 bits per slot
//   price_orders          64 bits per slot
//   size_orders           32 bits per slot
//   side_orders           2 bits per slot
//   kill                  blocks new grants and new pending sets
//   m_data/m_valid/m_ready/m_last   outbound beat stream (m_last on beat 2)
//   sent[N]               one-cycle pulse when a slot's message completes
//   pending[N]            registered pending flags (debug)
//   seq                   sequence number of the next message
// ---------------------------------------------------------------------------
module fire_order_dispatcher
  import gg_order_pkg::*;
#(
  parameter int MAX_INSTRUMENTS = 8,
  parameter int SEQ_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_INSTRUMENTS-1:0]    fire,
  input  logic [32*MAX_INSTRUMENTS-1:0] security_id_orders,
  input  logic [64*MAX_INSTRUMENTS-1:0] price_orders,
  input  logic [32*MAX_INSTRUMENTS-1:0] size_orders,
  input  logic [2*MAX_INSTRUMENTS-1:0]  side_orders,
  input  logic                          kill,
  output logic [63:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [MAX_INSTRUMENTS-1:0]    sent,
  output logic [MAX_INSTRUMENTS-1:0]    pending,
  output logic [SEQ_WIDTH-1:0]          seq
);

  localparam int IDX_W = $clog2(MAX_INSTRUMENTS);

  // Per-slot templates unpacked from the flat input buses.
  order_tmpl_t tmpl_arr [MAX_INSTRUMENTS];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_INSTRUMENTS; gi++) begin : g_unpack
      assign tmpl_arr[gi] = {security_id_orders[gi*32 +: 32],
                             price_orders[gi*64 +: 64],
                             size_orders[gi*32 +: 32],
                             side_orders[gi*2 +: 2]};
    end
  endgenerate

  dispatch_state_t              state_q, state_d;
  logic [MAX_INSTRUMENTS-1:0]   fire_q;
  logic [MAX_INSTRUMENTS-1:0]   pending_q, pending_d;
  logic [MAX_INSTRUMENTS-1:0]   sent_q, sent_d;
  order_tmpl_t                  msg_q, msg_d;
  logic [IDX_W-1:0]             slot_q, slot_d;
  logic [SEQ_WIDTH-1:0]         seq_q, seq_d;

  logic [MAX_INSTRUMENTS-1:0]   fire_rise;
  logic [MAX_INSTRUMENTS-1:0]   pending_set;
  logic [MAX_INSTRUMENTS-1:0]   pending_clr;
  logic                         grant_fire;
  logic [MAX_INSTRUMENTS-1:0]   grant_onehot;
  logic [IDX_W-1:0]             grant_idx;
  logic [IDX_W-1:0]             rr_ptr;
  logic [SEQ_FIELD_W-1:0]       seq_field;
  logic [SLOT_FIELD_W-1:0]      slot_field;

  assign fire_rise   = fire & ~fire_q;
  assign pending_set = kill ? '0 : fire_rise;
  assign seq_field   = SEQ_FIELD_W'(seq_q);
  assign slot_field  = SLOT_FIELD_W'(slot_q);

  rr_arbiter #(
    .N (MAX_INSTRUMENTS)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (pending_q),
    .advance      (grant_fire),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .ptr          (rr_ptr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fire_q    <= '0;
      pending_q <= '0;
      sent_q    <= '0;
      msg_q     <= '0;
      slot_q    <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      fire_q    <= fire;
      pending_q <= pending_d;
      sent_q    <= sent_d;
      msg_q     <= msg_d;
      slot_q    <= slot_d;
      seq_q     <= seq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    slot_d      = slot_q;
    seq_d       = seq_q;
    sent_d      = '0;
    pending_clr = '0;
    grant_fire  = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;

    case (state_q)
      IDLE: begin
        // Template is captured here so later template edits cannot
        // disturb the message once it has been granted.
        if (|pending_q && !kill) begin
          grant_fire  = 1'b1;
          msg_d       = tmpl_arr[grant_idx];
          slot_d      = grant_idx;
          pending_clr = grant_onehot;
          state_d     = BEAT0;
        end
      end
      BEAT0: begin
        m_valid                      = 1'b1;
        m_data[B0_ID_LSB +: 32]      = msg_q.security_id;
        m_data[B0_SIZE_LSB +: 32]    = msg_q.size;
        if (m_ready) state_d = BEAT1;
      end
      BEAT1: begin
        m_valid = 1'b1;
        m_data  = msg_q.price;
        if (m_ready) state_d = BEAT2;
      end
      BEAT2: begin
        m_valid                            = 1'b1;
        m_last                             = 1'b1;
        m_data[B2_SEQ_LSB +: SEQ_FIELD_W]  = seq_field;
        m_data[B2_SIDE_LSB +: 2]           = msg_q.side;
        m_data[B2_SLOT_LSB +: SLOT_FIELD_W] = slot_field;
        if (m_ready) begin
          state_d        = IDLE;
          seq_d          = seq_q + SEQ_WIDTH'(1);
          sent_d[slot_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge landing on the same cycle as the grant of that slot must
    // survive, so the set is applied after the clear.
    pending_d = (pending_q & ~pending_clr) | pending_set;
  end

  assign sent    = sent_q;
  assign pending = pending_q;
  assign seq     = seq_q;

endmodule
